// File: rtl/mmio_ctrl_if.sv
// CPU data-memory request bus as seen by the MMIO block: the request fields
// come from EX, the hit flag and the registered load data go back.
interface mmio_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mmio_hit;
    logic [31:0] rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  mmio_hit, rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output mmio_hit, rdata
    );
endinterface

// File: rtl/mmio_ctrl.sv
// Memory-mapped peripheral block: UART TX/RX one-entry buffers, a sticky TX
// overrun flag, and free-running cycle / retired-instruction counters.
module mmio_ctrl #(
    parameter logic [3:0] MMIO_TOP  = 4'h8,
    parameter int         CNT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mmio_ctrl_if.slave bus,
    input  logic       inst_retire,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_valid,
    input  logic       uart_tx_ready,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_valid,
    output logic       uart_rx_ready
);
    localparam logic [7:0] OFF_CTRL = 8'h00;
    localparam logic [7:0] OFF_RX   = 8'h04;
    localparam logic [7:0] OFF_TX   = 8'h08;
    localparam logic [7:0] OFF_CYC  = 8'h10;
    localparam logic [7:0] OFF_INST = 8'h14;
    localparam logic [7:0] OFF_CLR  = 8'h18;

    typedef enum logic {TX_EMPTY, TX_FULL} tx_state_t;

    tx_state_t            tx_state, tx_next;
    logic [7:0]           tx_buf;
    logic [7:0]           rx_buf;
    logic                 rx_full;
    logic                 tx_overrun;
    logic                 run;
    logic [CNT_WIDTH-1:0] cyc_cnt;
    logic [CNT_WIDTH-1:0] inst_cnt;
    logic [31:0]          rd_mux;
    logic [7:0]           off;
    logic                 hit, ld_hit, st_hit;
    logic                 st_tx, st_ctrl, st_clr, ld_rx;
    logic                 tx_fire, rx_fire;
    logic                 unused_bits;

    // Address decode: only the top nibble selects the block, only [7:0] picks a register.
    assign hit          = bus.req_valid & (bus.req_addr[31:28] == MMIO_TOP);
    assign bus.mmio_hit = hit;
    assign off          = bus.req_addr[7:0];
    assign ld_hit       = hit & ~bus.req_we;
    assign st_hit       = hit &  bus.req_we;
    assign st_tx        = st_hit & (off == OFF_TX);
    assign st_ctrl      = st_hit & (off == OFF_CTRL);
    assign st_clr       = st_hit & (off == OFF_CLR);
    assign ld_rx        = ld_hit & (off == OFF_RX);
    assign unused_bits  = ^{bus.req_addr[27:8], bus.req_wdata[31:8]};

    // UART handshakes. RX ready is held low until the first edge after reset.
    assign uart_tx_valid = (tx_state == TX_FULL);
    assign uart_tx_data  = tx_buf;
    assign tx_fire       = uart_tx_valid & uart_tx_ready;
    assign uart_rx_ready = run & ~rx_full;
    assign rx_fire       = uart_rx_valid & uart_rx_ready;

    // TX buffer state register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) tx_state <= TX_EMPTY;
        else      tx_state <= tx_next;
    end

    // TX buffer next state: fill on a store while empty, drain on handshake.
    always_comb begin
        // NOTE: default first so no path leaves tx_next unassigned (no latch).
        tx_next = tx_state;
        case (tx_state)
            TX_EMPTY: if (st_tx)   tx_next = TX_FULL;
            TX_FULL:  if (tx_fire) tx_next = TX_EMPTY;
        endcase
    end

    // TX data latch and sticky overrun; a store while full is dropped.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: buffers are reset too so a byte held across reset cannot reappear.
        if (!rst) begin
            tx_buf     <= '0;
            tx_overrun <= 1'b0;
        end else begin
            if (st_tx && tx_state == TX_EMPTY) tx_buf <= bus.req_wdata[7:0];
            if (st_tx && tx_state == TX_FULL)  tx_overrun <= 1'b1;
            else if (st_ctrl)                  tx_overrun <= 1'b0;
        end
    end

    // RX buffer: accept when ready, free when software reads the data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_buf  <= '0;
            rx_full <= 1'b0;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            if (rx_fire) begin
                rx_buf  <= uart_rx_data;
                rx_full <= 1'b1;
            end else if (ld_rx) begin
                rx_full <= 1'b0;
            end
        end
    end

    // Counters: clear wins over increment in the same cycle; both wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else if (st_clr) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt  <= cyc_cnt + CNT_WIDTH'(1);
            inst_cnt <= inst_cnt + CNT_WIDTH'(inst_retire);
        end
    end

    // Read mux over current state; unmapped and write-only offsets read 0.
    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL: rd_mux = {29'd0, tx_overrun, rx_full, tx_state == TX_EMPTY};
            OFF_RX:   rd_mux = {24'd0, rx_full ? rx_buf : 8'h00};
            OFF_CYC:  rd_mux = 32'(cyc_cnt);
            OFF_INST: rd_mux = 32'(inst_cnt);
            default:  rd_mux = '0;
        endcase
    end

    // Load data register: valid only in the cycle after a hit load, else 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bus.rdata <= '0;
        else      bus.rdata <= ld_hit ? rd_mux : 32'd0;
    end
endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: stimulus pushes expected load data and TX
// bytes into queues, independent monitors pop and compare on DUT output.
module tb_mmio_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       inst_retire;
    logic       tx_ready, tx_valid, rx_valid, rx_ready;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid2, rx_ready2;
    logic [7:0] tx_data2;
    logic       tx_ready2 = 1'b1;
    logic       rx_valid2 = 1'b0;
    logic [7:0] rx_data2  = 8'h00;
    logic       inst2     = 1'b0;

    mmio_ctrl_if bus ();
    mmio_ctrl_if bus2 ();

    mmio_ctrl dut (
        .clk(clk), .rst(rst), .bus(bus), .inst_retire(inst_retire),
        .uart_tx_data(tx_data), .uart_tx_valid(tx_valid), .uart_tx_ready(tx_ready),
        .uart_rx_data(rx_data), .uart_rx_valid(rx_valid), .uart_rx_ready(rx_ready)
    );

    // Narrow-counter instance so counter wrap is reachable in a short run.
    mmio_ctrl #(.MMIO_TOP(4'h8), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .bus(bus2), .inst_retire(inst2),
        .uart_tx_data(tx_data2), .uart_tx_valid(tx_valid2), .uart_tx_ready(tx_ready2),
        .uart_rx_data(rx_data2), .uart_rx_valid(rx_valid2), .uart_rx_ready(rx_ready2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } ld_exp_t;

    ld_exp_t    ldq[$];
    logic [7:0] txq[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         edges   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) edges++;
        #1;
    endtask

    task automatic ld(input logic [31:0] addr, input string name, input logic [31:0] exp);
        ld_exp_t e;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = addr;
        bus.req_wdata = 32'd0;
        e.name = name;
        e.exp  = exp;
        ldq.push_back(e);
        #1 check("ld_hit", 32'(bus.mmio_hit), 32'd1);
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] data);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        #1 check("st_hit", 32'(bus.mmio_hit), 32'd1);
        step();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic nh(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        #1 check("nonhit", 32'(bus.mmio_hit), 32'd0);
        step();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    // Load monitor: rdata must carry the queued value after a hit load, else 0.
    initial begin : ld_mon
        logic    pend;
        ld_exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (ldq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL ld_unexpected: got 0x%08h with no load queued", bus.rdata);
                    end else begin
                        e = ldq.pop_front();
                        check(e.name, bus.rdata, e.exp);
                    end
                end else begin
                    check("rdata_idle", bus.rdata, 32'd0);
                end
                pend = bus.req_valid && !bus.req_we && (bus.req_addr[31:28] == 4'h8);
            end
        end
    end

    // TX monitor: every handshake must match the next expected byte.
    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (rst && tx_valid && tx_ready) begin
                if (txq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got 0x%02h with no byte queued", tx_data);
                end else begin
                    check("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [9:0] pat;
        pat = 10'b1011011011;
        rst = 1'b0;
        inst_retire = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        bus2.req_valid = 1'b0;
        bus2.req_we = 1'b0;
        bus2.req_addr = 32'd0;
        bus2.req_wdata = 32'd0;

        // Reset state.
        step();
        step();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        rst = 1'b1;
        edges = 0;
        #1 check("rx_ready_pre_edge", 32'(rx_ready), 32'd0);

        // Seven retirements in ten cycles, then read both counters.
        for (int i = 0; i < 10; i++) begin
            inst_retire = pat[i];
            step();
            if (i == 0) check("rx_ready_first_edge", 32'(rx_ready), 32'd1);
        end
        inst_retire = 1'b0;
        ld(32'h8000_0014, "inst_cnt_7", 32'd7);
        ld(32'h8000_0010, "cyc_cnt_11", 32'd11);

        // Single TX byte held off by ready for three cycles.
        txq.push_back(8'h41);
        st(32'h8000_0008, 32'h0000_0041);
        check("tx_hold_v0", 32'(tx_valid), 32'd1);
        check("tx_hold_d0", 32'(tx_data), 32'h41);
        for (int i = 0; i < 2; i++) begin
            step();
            check("tx_hold_v", 32'(tx_valid), 32'd1);
            check("tx_hold_d", 32'(tx_data), 32'h41);
        end
        tx_ready = 1'b1;
        #1 check("tx_hold_v3", 32'(tx_valid), 32'd1);
        step();
        check("tx_drained", 32'(tx_valid), 32'd0);
        ld(32'h8000_0000, "ctrl_after_tx", 32'h1);

        // Overrun: second store while full is dropped and flagged.
        tx_ready = 1'b0;
        txq.push_back(8'h41);
        st(32'h8000_0008, 32'h0000_0041);
        st(32'h8000_0008, 32'h0000_0042);
        check("ovr_data_kept", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        ld(32'h8000_0000, "ctrl_overrun", 32'h5);
        st(32'h8000_0000, 32'h0);
        ld(32'h8000_0000, "ctrl_ovr_clr", 32'h1);

        // RX: first byte fills the buffer, second waits for the read.
        rx_valid = 1'b1;
        rx_data = 8'h5A;
        step();
        rx_data = 8'h33;
        check("rx_full_ready", 32'(rx_ready), 32'd0);
        ld(32'h8000_0000, "ctrl_rx_full", 32'h3);
        ld(32'h8000_0004, "rx_5a", 32'h5A);
        check("rx_ready_again", 32'(rx_ready), 32'd1);
        step();
        rx_valid = 1'b0;
        check("rx_full_33", 32'(rx_ready), 32'd0);
        ld(32'h8000_0004, "rx_33", 32'h33);
        ld(32'h8000_0004, "rx_empty", 32'h0);

        // Unmapped / write-only offsets and non-hit requests.
        ld(32'h8000_000C, "unmapped_0c", 32'h0);
        ld(32'h8000_0008, "wo_tx", 32'h0);
        ld(32'h8000_0018, "wo_clr", 32'h0);
        nh(1'b1, 32'h0000_0008, 32'h77);
        check("nonhit_no_tx", 32'(tx_valid), 32'd0);
        nh(1'b0, 32'h4000_0010, 32'h0);

        // Counter clear beats a same-cycle retire; load before clear sees old value.
        ld(32'h8000_0014, "inst_pre_clr", 32'd7);
        inst_retire = 1'b1;
        st(32'h8000_0018, 32'hDEAD_BEEF);
        inst_retire = 1'b0;
        ld(32'h8000_0010, "cyc_clr_0", 32'd0);
        ld(32'h8000_0010, "cyc_clr_1", 32'd1);
        ld(32'h8000_0014, "inst_clr_0", 32'd0);

        // Reset in the middle of a held TX byte and a full RX buffer.
        rx_valid = 1'b1;
        rx_data = 8'h66;
        step();
        rx_valid = 1'b0;
        st(32'h8000_0008, 32'h55);
        check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
        ld(32'h8000_0000, "ctrl_pre_rst", 32'h2);
        #6 rst = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        check("mid_rst_rdata", bus.rdata, 32'd0);
        step();
        step();
        rst = 1'b1;
        edges = 0;
        step();
        ld(32'h8000_0004, "rx_after_rst", 32'h0);
        ld(32'h8000_0000, "ctrl_after_rst", 32'h1);

        // Wrap of the 4-bit cycle counter: 15 then 0.
        while (edges % 16 != 15) step();
        bus2.req_valid = 1'b1;
        bus2.req_addr = 32'h8000_0010;
        step();
        check("wrap_max", bus2.rdata, 32'd15);
        step();
        check("wrap_zero", bus2.rdata, 32'd0);
        bus2.req_valid = 1'b0;

        step();
        @(negedge clk);
        #1;
        check("ldq_drained", 32'(ldq.size()), 32'd0);
        check("txq_drained", 32'(txq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameter: MMIO_TOP, default 4'h8, the req_addr[31:28] value that selects this block.
REQ-002 Parameter: CNT_WIDTH, default 32, the width of the cycle and instruction counters (≤32, zero-extended on rdata).
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  in  1  CPU data-memory access in EX this cycle.
REQ-006 Port: req_we  in  1  1=store, 0=load.
REQ-007 Port: req_addr  in  32  byte address (ALU result).
REQ-008 Port: req_wdata  in  32  store data.
REQ-009 Port: inst_retire  in  1  one-cycle pulse per retired instruction.
REQ-010 Port: mmio_hit  out  1  combinational; req_valid & (req_addr[31:28]==MMIO_TOP).
REQ-011 Port: rdata  out  32  registered load data.
REQ-012 Port: uart_tx_data / uart_tx_valid  out  8 / 1  UART transmit channel; uart_tx_ready  in  1.
REQ-013 Port: uart_rx_data / uart_rx_valid  in  8 / 1  UART receive channel; uart_rx_ready  out  1.

Function
REQ-014 Register map on req_addr[7:0]:
- 0x00: control (RO): bit0 = tx_empty, bit1 = rx_full, bit2 = tx_overrun; other bits 0.
- 0x04: RX data (RO): [7:0].
- 0x08: TX data (WO): [7:0].
- 0x10: cycle count (RO).
- 0x14: instruction count (RO).
- 0x18: counter clear (WO).
REQ-015 Loads from unmapped or WO offsets SHALL return 0; stores to RO or unmapped offsets SHALL be ignored, except a store to 0x00, which SHALL clear tx_overrun.
REQ-016 Load latency SHALL be exactly 1 cycle: a hit load in cycle N drives rdata in cycle N+1 with state sampled in cycle N; in any cycle not following a hit load, rdata SHALL be 0.
REQ-017 TX SHALL be a one-entry buffer with states EMPTY and FULL.
- EMPTY -> FULL on a hit store to 0x08; the buffer latches req_wdata[7:0].
- FULL -> EMPTY on uart_tx_valid & uart_tx_ready.
REQ-018 uart_tx_valid SHALL equal FULL, and uart_tx_data SHALL be stable while FULL.
REQ-019 A hit store to 0x08 while FULL SHALL NOT be handed off in the same cycle; it SHALL be dropped, the buffer SHALL be unchanged, and tx_overrun SHALL be set (sticky).
REQ-020 RX SHALL be a one-entry buffer, and uart_rx_ready SHALL equal ~rx_full.
- Accept on uart_rx_valid & uart_rx_ready: latch data and set rx_full.
REQ-021 A hit load of 0x04 SHALL return the buffer content (0 if empty) and clear rx_full in the same edge.
- An arrival in that same cycle cannot occur because ready=0 while full.
REQ-022 The cycle counter SHALL increment by 1 every cycle.
REQ-023 The instruction counter SHALL increment by 1 on each cycle with inst_retire=1.
REQ-024 Both counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-025 A hit store to 0x18 SHALL load 0 into both counters on that edge, taking priority over any increment in the same cycle; the data value is ignored.
REQ-026 A load of a counter and a clear in different cycles are independent: a load in the cycle before the clear returns the pre-clear value.
REQ-027 A non-hit request (mmio_hit=0) SHALL cause no state change other than counter increments.

Reset
REQ-028 While rst=0, asynchronously:
- TX EMPTY, RX empty, tx_overrun=0, both counters 0, rdata=0.
- uart_tx_valid=0, uart_tx_data=0, uart_rx_ready=0.
REQ-029 After rst rises, uart_rx_ready SHALL go to 1 on the first clock edge, and counting SHALL begin on that edge (cycle count reads 1 one cycle later).
REQ-030 Reset asserted mid-transfer (TX FULL or RX full) SHALL discard the buffered byte with no further handshake.

Verification
REQ-031 Store 0x41 to 0x8000_0008 with uart_tx_ready=0 for 3 cycles, then 1 -> uart_tx_valid=1, data=0x41 for 4 cycles, then 0; control read = 0x1.
REQ-032 Two back-to-back stores 0x41, 0x42 to 0x08 with uart_tx_ready=0 -> only 0x41 transmitted; control read = 0x5; store to 0x00, then control read = 0x1 after drain.
REQ-033 Drive uart_rx_valid with 0x5A, then hold valid with 0x33 -> uart_rx_ready=0, control bit1=1; load 0x04 returns 0x5A; next cycle ready=1 and 0x33 is accepted.
REQ-034 Pulse inst_retire on 7 of 10 cycles after reset, then load 0x14 and 0x10 -> instruction count 7, cycle count equal to the edge count since reset release.
REQ-035 Store to 0x18 in a cycle with inst_retire=1 -> both counters read 0 then 1 (cycle) / 0 (inst) on subsequent loads; force the cycle counter to 0xFFFF_FFFF -> reads 0 next cycle.
REQ-036 Assert rst with TX FULL -> uart_tx_valid drops immediately; rdata=0; load 0x04 returns 0.
